// File: rtl/aes_key_schedule.sv
// rtl/aes_key_schedule.sv - iterative AES-128/192/256 key expander with registered round-key read port
//
// Ports:
//   clk, resetn        clock; asynchronous active-low reset
//   start              one-cycle request to latch cipher_key/key_len and expand
//   key_len[1:0]       0=AES-128, 1=AES-192, 2=AES-256, 3=illegal
//   cipher_key         MSB-aligned key, w[0] in the top 32 bits
//   round_sel[3:0]     round index to read
//   busy               expansion in progress
//   key_rdy            storage holds a complete schedule
//   key_err            one-cycle pulse when start is rejected
//   round_key[127:0]   registered w[4r..4r+3], w[4r] in the top word

module aes_key_schedule #(
    parameter int MAX_KEY_WIDTH = 256
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     start,
    input  logic [1:0]               key_len,
    input  logic [MAX_KEY_WIDTH-1:0] cipher_key,
    input  logic [3:0]               round_sel,
    output logic                     busy,
    output logic                     key_rdy,
    output logic                     key_err,
    output logic [127:0]             round_key
);

    localparam int NK_MAX = MAX_KEY_WIDTH / 32;
    localparam int NR_MAX = NK_MAX + 6;
    localparam int NW     = 4 * (NR_MAX + 1);

    // FIPS-197 S-box, entry 0 in the most significant byte.
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    typedef enum logic [1:0] {IDLE, LOAD, EXPAND, DONE} state_t;

    state_t                   state;
    logic [1:0]               len_q;
    logic [MAX_KEY_WIDTH-1:0] key_q;
    logic [31:0]              w [NW];
    logic [5:0]               i_q;
    logic [2:0]               j_q;      // i_q mod Nk, kept separately since Nk=6 is not a power of two
    logic [7:0]               rcon;

    logic [3:0]  nk;
    logic [3:0]  nr;
    logic [5:0]  last_idx;
    logic        start_legal;
    logic [31:0] prev;
    logic [31:0] back;
    logic [31:0] temp;
    logic [5:0]  base;

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[{~b, 3'b000} +: 8];
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] x);
        return {sbox(x[31:24]), sbox(x[23:16]), sbox(x[15:8]), sbox(x[7:0])};
    endfunction

    assign nk       = 4'd4 + {1'b0, len_q, 1'b0};
    assign nr       = 4'd10 + {1'b0, len_q, 1'b0};
    assign last_idx = {nr, 2'b11};

    // Key lengths wider than the storage was built for are rejected like code 3.
    assign start_legal = (key_len != 2'd3) && ((32'(key_len) * 64 + 128) <= MAX_KEY_WIDTH);

    assign prev = w[i_q - 6'd1];
    assign back = w[i_q - {2'b00, nk}];

    always_comb begin
        temp = prev;
        if (j_q == 3'd0) begin
            temp = sub_word({prev[23:0], prev[31:24]}) ^ {rcon, 24'h000000};
        end else if (len_q == 2'd2 && j_q == 3'd4) begin
            temp = sub_word(prev);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state   <= IDLE;
            busy    <= 1'b0;
            key_rdy <= 1'b0;
            key_err <= 1'b0;
            len_q   <= 2'd0;
            key_q   <= '0;
            i_q     <= 6'd0;
            j_q     <= 3'd0;
            rcon    <= 8'h01;
            for (int k = 0; k < NW; k++) begin
                w[k] <= 32'h0;
            end
        end else begin
            key_err <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        if (start_legal) begin
                            len_q   <= key_len;
                            key_q   <= cipher_key;
                            key_rdy <= 1'b0;
                            state   <= LOAD;
                        end else begin
                            key_err <= 1'b1;
                        end
                    end
                end
                LOAD: begin
                    for (int k = 0; k < NK_MAX; k++) begin
                        if (k < 32'(nk)) begin
                            w[k] <= key_q[MAX_KEY_WIDTH-1-32*k -: 32];
                        end
                    end
                    i_q   <= {2'b00, nk};
                    j_q   <= 3'd0;
                    rcon  <= 8'h01;
                    busy  <= 1'b1;
                    state <= EXPAND;
                end
                EXPAND: begin
                    w[i_q] <= back ^ temp;
                    if (j_q == 3'd0) begin
                        rcon <= {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
                    end
                    j_q <= ({1'b0, j_q} == nk - 4'd1) ? 3'd0 : j_q + 3'd1;
                    i_q <= i_q + 6'd1;
                    if (i_q == last_idx) begin
                        busy    <= 1'b0;
                        key_rdy <= 1'b1;
                        state   <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign base = {round_sel, 2'b00};

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            round_key <= 128'h0;
        end else if (key_rdy && round_sel <= nr) begin
            round_key <= {w[base], w[base + 6'd1], w[base + 6'd2], w[base + 6'd3]};
        end else begin
            round_key <= 128'h0;
        end
    end

endmodule

// File: tb/tb_aes_key_schedule.sv
// tb/tb_aes_key_schedule.sv - scoreboard bench for aes_key_schedule against a GF(2^8) reference model

module tb_aes_key_schedule;

    logic         clk = 1'b0;
    logic         resetn;
    logic         start;
    logic [1:0]   key_len;
    logic [255:0] cipher_key;
    logic [3:0]   round_sel;
    logic         busy, key_rdy, key_err;
    logic [127:0] round_key;

    logic         start_s;
    logic [1:0]   key_len_s;
    logic [127:0] cipher_key_s;
    logic [3:0]   round_sel_s;
    logic         busy_s, key_rdy_s, key_err_s;
    logic [127:0] round_key_s;

    always #5 clk = ~clk;

    aes_key_schedule #(.MAX_KEY_WIDTH(256)) dut (
        .clk(clk), .resetn(resetn), .start(start), .key_len(key_len),
        .cipher_key(cipher_key), .round_sel(round_sel), .busy(busy),
        .key_rdy(key_rdy), .key_err(key_err), .round_key(round_key)
    );

    aes_key_schedule #(.MAX_KEY_WIDTH(128)) dut128 (
        .clk(clk), .resetn(resetn), .start(start_s), .key_len(key_len_s),
        .cipher_key(cipher_key_s), .round_sel(round_sel_s), .busy(busy_s),
        .key_rdy(key_rdy_s), .key_err(key_err_s), .round_key(round_key_s)
    );

    int           n_checks = 0;
    int           n_fail   = 0;
    logic [7:0]   ref_sbox [256];
    logic [31:0]  ref_w [60];
    logic [127:0] exp_q [$];
    logic         rd_req  = 1'b0;
    logic         rd_seen = 1'b0;

    localparam logic [127:0] K128 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [191:0] K192 = 192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b;
    localparam logic [255:0] K256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x, y;
        p = 8'h00; x = a; y = b;
        for (int k = 0; k < 8; k++) begin
            if (y[0]) p = p ^ x;
            x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
        logic [15:0] d;
        d = {v, v} << n;
        return d[15:8];
    endfunction

    // S-box from its definition: multiplicative inverse followed by the affine map.
    task automatic build_sbox();
        for (int a = 0; a < 256; a++) begin
            logic [7:0] inv;
            inv = 8'h00;
            for (int c = 1; c < 256; c++) begin
                if (gmul(8'(a), 8'(c)) == 8'h01) inv = 8'(c);
            end
            ref_sbox[a] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [31:0] subw(input logic [31:0] t);
        return {ref_sbox[t[31:24]], ref_sbox[t[23:16]], ref_sbox[t[15:8]], ref_sbox[t[7:0]]};
    endfunction

    task automatic model(input logic [255:0] key, input int len);
        int nk, nr;
        logic [31:0] t;
        logic [7:0]  rc;
        nk = 4 + 2 * len;
        nr = 10 + 2 * len;
        for (int i = 0; i < nk; i++) ref_w[i] = key[255 - 32 * i -: 32];
        for (int i = nk; i < 4 * (nr + 1); i++) begin
            t = ref_w[i - 1];
            if (i % nk == 0) begin
                rc = 8'h01;
                for (int p = 1; p < i / nk; p++) rc = gmul(rc, 8'h02);
                t = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
            end else if (nk == 8 && i % nk == 4) begin
                t = subw(t);
            end
            ref_w[i] = ref_w[i - nk] ^ t;
        end
    endtask

    always @(posedge clk) rd_seen <= rd_req;

    always @(negedge clk) begin
        if (rd_seen) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL scoreboard_empty: got %h, expected queued entry", round_key);
            end else begin
                chk("round_key", round_key, exp_q.pop_front());
            end
        end
    end

    task automatic read(input int r, input logic [127:0] exp);
        round_sel = 4'(r);
        rd_req = 1'b1;
        exp_q.push_back(exp);
        @(posedge clk); #1;
        rd_req = 1'b0;
    endtask

    task automatic read_all(input int len);
        for (int r = 0; r < 16; r++) begin
            if (r <= 10 + 2 * len) read(r, {ref_w[4*r], ref_w[4*r+1], ref_w[4*r+2], ref_w[4*r+3]});
            else read(r, 128'h0);
        end
    endtask

    task automatic run(input logic [255:0] key, input int len, input int ign);
        int cnt, nk, nr;
        logic ok;
        nk = 4 + 2 * len;
        nr = 10 + 2 * len;
        @(posedge clk); #1;
        start = 1'b1; key_len = 2'(len); cipher_key = key;
        @(posedge clk); #1;
        start = 1'b0;
        chk("key_rdy_clear", {127'h0, key_rdy}, 128'h0);
        cnt = 0;
        ok = 1'b1;
        while (!key_rdy && cnt < 200) begin
            if (cnt >= 1 && !busy) ok = 1'b0;
            if (ign > 0 && cnt == ign) begin
                start = 1'b1; key_len = 2'd0; cipher_key = {$urandom, $urandom, $urandom, $urandom, 128'h0};
            end
            @(posedge clk); #1;
            start = 1'b0;
            cnt++;
            if (busy && key_rdy) ok = 1'b0;
        end
        chk("latency", 128'(cnt), 128'(1 + 4 * (nr + 1) - nk));
        chk("busy_profile", {127'h0, ok}, 128'h1);
        chk("busy_done", {127'h0, busy}, 128'h0);
        chk("no_err", {127'h0, key_err}, 128'h0);
        model(key, len);
    endtask

    task automatic illegal_start(input logic exp_rdy);
        @(posedge clk); #1;
        start = 1'b1; key_len = 2'd3; cipher_key = {8{$urandom}};
        @(posedge clk); #1;
        start = 1'b0;
        chk("err_pulse", {127'h0, key_err}, 128'h1);
        chk("err_busy", {127'h0, busy}, 128'h0);
        @(posedge clk); #1;
        chk("err_clear", {127'h0, key_err}, 128'h0);
        chk("err_rdy", {127'h0, key_rdy}, {127'h0, exp_rdy});
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        int cnt;
        logic [255:0] rk;
        int rl;
        build_sbox();
        resetn = 1'b0; start = 1'b0; key_len = 2'd0; cipher_key = '0; round_sel = 4'd0;
        start_s = 1'b0; key_len_s = 2'd0; cipher_key_s = '0; round_sel_s = 4'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", {127'h0, busy}, 128'h0);
        chk("rst_rdy", {127'h0, key_rdy}, 128'h0);
        chk("rst_err", {127'h0, key_err}, 128'h0);
        chk("rst_key", round_key, 128'h0);
        resetn = 1'b1;

        illegal_start(1'b0);

        run({K128, 128'h0}, 0, 0);
        read(0, K128);
        read(1, 128'ha0fafe1788542cb123a339392a6c7605);
        read(10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        read(11, 128'h0);

        run({K192, 64'h0}, 1, 0);
        read(12, 128'he98ba06f448c773c8ecc720401002202);
        read(13, 128'h0);

        run(K256, 2, 0);
        read(14, 128'hfe4890d1e6188d0b046df344706c631e);
        read(15, 128'h0);

        illegal_start(1'b1);
        read(14, 128'hfe4890d1e6188d0b046df344706c631e);

        run({K128, 128'hdeadbeef_0badf00d_12345678_9abcdef0}, 0, 10);
        read(1, 128'ha0fafe1788542cb123a339392a6c7605);
        read(10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

        for (int it = 0; it < 6; it++) begin
            rl = $urandom_range(0, 2);
            rk = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            run(rk, rl, 0);
            read_all(rl);
        end

        @(posedge clk); #1;
        start = 1'b1; key_len = 2'd2; cipher_key = K256;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (13) @(posedge clk);
        #1;
        chk("mid_busy", {127'h0, busy}, 128'h1);
        #2;
        resetn = 1'b0;
        #1;
        chk("abort_busy", {127'h0, busy}, 128'h0);
        chk("abort_rdy", {127'h0, key_rdy}, 128'h0);
        chk("abort_err", {127'h0, key_err}, 128'h0);
        chk("abort_key", round_key, 128'h0);
        @(posedge clk); #1;
        resetn = 1'b1;
        run({K128, 128'h0}, 0, 0);
        read_all(0);
        read(10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

        @(posedge clk); #1;
        start_s = 1'b1; key_len_s = 2'd2; cipher_key_s = K128;
        @(posedge clk); #1;
        start_s = 1'b0;
        chk("narrow_err", {127'h0, key_err_s}, 128'h1);
        chk("narrow_busy", {127'h0, busy_s}, 128'h0);
        start_s = 1'b1; key_len_s = 2'd0;
        @(posedge clk); #1;
        start_s = 1'b0;
        cnt = 0;
        while (!key_rdy_s && cnt < 200) begin
            @(posedge clk); #1;
            cnt++;
        end
        chk("narrow_latency", 128'(cnt), 128'd41);
        round_sel_s = 4'd10;
        @(posedge clk); #1;
        chk("narrow_r10", round_key_s, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_drained", 128'(exp_q.size()), 128'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
